// File: rtl/free_addr_mgr_pkg.sv
// Shared switch parameters for the free address manager and its neighbours.
package free_addr_mgr_pkg;

    localparam int ADDR_W        = 12;
    localparam int address_width = ADDR_W;
    localparam int NUM_CELLS_DEF = 4096;
    localparam int AE_THRESH_DEF = 16;

endpackage

// File: rtl/free_addr_mgr_if.sv
// Allocation / free handshake between the cell manager and its clients.
interface free_addr_mgr_if #(
    parameter int ADDR_W = free_addr_mgr_pkg::ADDR_W
);

    logic              alloc_req;
    logic              alloc_gnt;
    logic              alloc_vld;
    logic [ADDR_W-1:0] alloc_addr;
    logic              free_vld;
    logic [ADDR_W-1:0] free_addr;

    modport master (
        output alloc_req, free_vld, free_addr,
        input  alloc_gnt, alloc_vld, alloc_addr
    );

    modport slave (
        input  alloc_req, free_vld, free_addr,
        output alloc_gnt, alloc_vld, alloc_addr
    );

endinterface

// File: rtl/free_addr_mgr_ram.sv
// Free list storage: simple dual-port RAM, one write port, one registered read port.
module free_list_ram #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr[IW-1:0]] <= wdata;
        if (re) rdata <= mem[raddr[IW-1:0]];
    end

endmodule

// File: rtl/free_addr_mgr.sv
// Free cell address manager: circular free list, initialised with every cell index after reset.
//   state   | meaning
//   ST_INIT | writing index i into entry i, one per cycle; no grants, frees ignored
//   ST_RUN  | serving allocations from rd_ptr and accepting frees at wr_ptr
module free_addr_mgr
    import free_addr_mgr_pkg::*;
#(
    parameter int ADDR_W    = free_addr_mgr_pkg::ADDR_W,
    parameter int NUM_CELLS = NUM_CELLS_DEF,
    parameter int AE_THRESH = AE_THRESH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    free_addr_mgr_if.slave    bus,
    output logic [ADDR_W:0]   free_cnt,
    output logic              init_done,
    output logic              almost_empty,
    output logic              empty,
    output logic              err_overflow
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CELLS - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(NUM_CELLS);
    localparam logic [ADDR_W:0]   AE_CNT   = (ADDR_W+1)'(AE_THRESH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_idx_q, init_idx_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] alloc_addr_q, alloc_addr_d;
    logic [ADDR_W:0]   free_cnt_q, free_cnt_d;
    logic              init_done_q, init_done_d;
    logic              alloc_vld_q, alloc_vld_d;
    logic              err_q, err_d;
    logic              empty_q, empty_d;
    logic              ae_q, ae_d;

    logic              gnt;
    logic              free_acc;
    logic              addr_ok;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_rdata;

    function automatic logic [ADDR_W-1:0] inc_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + ADDR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_idx_q == LAST_IDX) state_d = ST_RUN;
    end

    always_comb begin
        addr_ok   = ({1'b0, bus.free_addr} < FULL_CNT);
        gnt       = 1'b0;
        free_acc  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = init_idx_q;
        ram_wdata = init_idx_q;
        case (state_q)
            ST_INIT: ram_we = 1'b1;
            ST_RUN: begin
                // No bypass: a free this cycle cannot satisfy a request while the list is empty.
                gnt       = bus.alloc_req && (free_cnt_q != '0);
                free_acc  = bus.free_vld && (free_cnt_q < FULL_CNT) && addr_ok;
                ram_we    = free_acc;
                ram_waddr = wr_ptr_q;
                ram_wdata = bus.free_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        init_idx_d   = init_idx_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        free_cnt_d   = free_cnt_q;
        init_done_d  = init_done_q;
        err_d        = err_q;
        alloc_vld_d  = gnt;
        alloc_addr_d = bus.alloc_addr;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + ADDR_W'(1);
            if (init_idx_q == LAST_IDX) begin
                init_idx_d  = '0;
                init_done_d = 1'b1;
                free_cnt_d  = FULL_CNT;
                rd_ptr_d    = '0;
                wr_ptr_d    = '0;
            end
        end else begin
            if (gnt)      rd_ptr_d = inc_ptr(rd_ptr_q);
            if (free_acc) wr_ptr_d = inc_ptr(wr_ptr_q);
            free_cnt_d = free_cnt_q + (ADDR_W+1)'(free_acc) - (ADDR_W+1)'(gnt);
            if (bus.free_vld && !free_acc) err_d = 1'b1;
        end
        empty_d = (free_cnt_d == '0);
        ae_d    = (free_cnt_d <= AE_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            init_idx_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            free_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            alloc_vld_q  <= 1'b0;
            alloc_addr_q <= '0;
            err_q        <= 1'b0;
            empty_q      <= 1'b1;
            ae_q         <= 1'b1;
        end else begin
            init_idx_q   <= init_idx_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            free_cnt_q   <= free_cnt_d;
            init_done_q  <= init_done_d;
            alloc_vld_q  <= alloc_vld_d;
            alloc_addr_q <= alloc_addr_d;
            err_q        <= err_d;
            empty_q      <= empty_d;
            ae_q         <= ae_d;
        end
    end

    free_list_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (NUM_CELLS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (gnt),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // RAM output is only meaningful the cycle after a read; otherwise replay the held address.
    assign bus.alloc_gnt  = gnt;
    assign bus.alloc_vld  = alloc_vld_q;
    assign bus.alloc_addr = alloc_vld_q ? ram_rdata : alloc_addr_q;

    assign free_cnt     = free_cnt_q;
    assign init_done    = init_done_q;
    assign almost_empty = ae_q;
    assign empty        = empty_q;
    assign err_overflow = err_q;

endmodule
